// File: rtl/trap_return_ctrl.sv
// Machine-mode trap entry / MRET return sequencer with the mstatus/mepc/mcause/mtvec
// state it owns and a held redirect handshake towards fetch.
module trap_return_ctrl #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic        mret_pulse,
    input  logic        csr_we,
    input  logic [1:0]  csr_sel,
    input  logic [31:0] csr_wdata,
    input  logic        redirect_ready,
    output logic        trap_ack,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        busy,
    output logic [1:0]  cur_priv,
    output logic        mie,
    output logic        mpie,
    output logic [1:0]  mpp,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtvec
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CODE_W    = 5;
    localparam int unsigned PAD_W     = XLEN - CODE_W - 2;

    localparam logic [1:0] PRIV_M     = 2'b11;
    localparam logic [1:0] PRIV_U     = 2'b00;

    localparam logic [1:0] SEL_MSTATUS = 2'b00;
    localparam logic [1:0] SEL_MEPC    = 2'b01;
    localparam logic [1:0] SEL_MTVEC   = 2'b10;

    localparam logic [1:0] MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        TRAP_SAVE    = 2'b01,
        MRET_RESTORE = 2'b10,
        REDIRECT     = 2'b11
    } state_t;

    state_t state;
    state_t state_d;

    logic            trap_take_c;
    logic            mret_take_c;
    logic            csr_take_c;
    logic            vectored_c;
    logic [XLEN-1:0] trap_base_c;
    logic [XLEN-1:0] trap_off_c;
    logic [XLEN-1:0] trap_target_c;
    logic [XLEN-1:0] mtvec_wval_c;

    // Only M and U exist, so any other encoding collapses to U.
    function automatic logic [1:0] legal_priv(input logic [1:0] v);
        return (v == PRIV_M) ? PRIV_M : PRIV_U;
    endfunction

    // Acceptance decisions: trap beats MRET, and either one suppresses a CSR write.
    always_comb begin
        trap_take_c = 1'b0;
        mret_take_c = 1'b0;
        csr_take_c  = 1'b0;
        if (state == IDLE) begin
            trap_take_c = trap_req;
            mret_take_c = !trap_req && mret_pulse && (cur_priv == PRIV_M);
            csr_take_c  = csr_we && !trap_take_c && !mret_take_c;
        end
    end

    // Trap target: direct base, or base + 4*code for vectored interrupts (wraps mod 2^32).
    always_comb begin
        trap_base_c   = {mtvec[XLEN-1:2], 2'b00};
        trap_off_c    = {PAD_W'(0), trap_cause[CODE_W-1:0], 2'b00};
        vectored_c    = (mtvec[1:0] == MODE_VECTORED) && trap_cause[XLEN-1];
        trap_target_c = vectored_c ? XLEN'(trap_base_c + trap_off_c) : trap_base_c;
    end

    // Reserved mtvec modes 10/11 fall back to direct mode.
    always_comb begin
        mtvec_wval_c = csr_wdata;
        if (csr_wdata[1]) begin
            mtvec_wval_c[1:0] = 2'b00;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (trap_take_c) begin
                    state_d = TRAP_SAVE;
                end else if (mret_take_c) begin
                    state_d = MRET_RESTORE;
                end
            end
            TRAP_SAVE:    state_d = REDIRECT;
            MRET_RESTORE: state_d = REDIRECT;
            REDIRECT: begin
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default:      state_d = IDLE;
        endcase
    end

    // State, registered handshake outputs and CSR state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            trap_ack       <= 1'b0;
            redirect_valid <= 1'b0;
            flush          <= 1'b0;
            busy           <= 1'b0;
            redirect_pc    <= '0;
            cur_priv       <= PRIV_M;
            mie            <= 1'b0;
            mpie           <= 1'b0;
            mpp            <= PRIV_M;
            mepc           <= '0;
            mcause         <= '0;
            mtvec          <= MTVEC_RST;
        end else begin
            state          <= state_d;
            trap_ack       <= (state_d == TRAP_SAVE);
            redirect_valid <= (state_d == REDIRECT);
            flush          <= (state_d == REDIRECT);
            busy           <= (state_d != IDLE);

            case (state)
                IDLE: begin
                    if (csr_take_c) begin
                        case (csr_sel)
                            SEL_MSTATUS: begin
                                mie  <= csr_wdata[3];
                                mpie <= csr_wdata[7];
                                mpp  <= legal_priv(csr_wdata[12:11]);
                            end
                            SEL_MEPC:  mepc  <= {csr_wdata[XLEN-1:2], 2'b00};
                            SEL_MTVEC: mtvec <= mtvec_wval_c;
                            default: ;
                        endcase
                    end
                end
                TRAP_SAVE: begin
                    mepc        <= {trap_pc[XLEN-1:2], 2'b00};
                    mcause      <= trap_cause;
                    mpie        <= mie;
                    mie         <= 1'b0;
                    mpp         <= cur_priv;
                    cur_priv    <= PRIV_M;
                    redirect_pc <= trap_target_c;
                end
                MRET_RESTORE: begin
                    cur_priv    <= mpp;
                    mie         <= mpie;
                    mpie        <= 1'b1;
                    mpp         <= PRIV_U;
                    redirect_pc <= mepc;
                end
                default: ;
            endcase
        end
    end

    logic unused_c;
    assign unused_c = ^{trap_cause[XLEN-2:CODE_W], trap_pc[1:0]};

endmodule

// File: tb/tb_trap_return_ctrl.sv
// Directed self-checking bench for trap_return_ctrl: trap entry, vectored entry,
// MRET return, arbitration, held redirect, CSR legalisation and async reset.
module tb_trap_return_ctrl;

    logic        clk;
    logic        rst_n;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret_pulse;
    logic        csr_we;
    logic [1:0]  csr_sel;
    logic [31:0] csr_wdata;
    logic        redirect_ready;
    logic        trap_ack;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;
    logic [1:0]  cur_priv;
    logic        mie;
    logic        mpie;
    logic [1:0]  mpp;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtvec;

    int tests = 0;
    int fails = 0;

    trap_return_ctrl #(.MTVEC_RST(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .mret_pulse     (mret_pulse),
        .csr_we         (csr_we),
        .csr_sel        (csr_sel),
        .csr_wdata      (csr_wdata),
        .redirect_ready (redirect_ready),
        .trap_ack       (trap_ack),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .busy           (busy),
        .cur_priv       (cur_priv),
        .mie            (mie),
        .mpie           (mpie),
        .mpp            (mpp),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtvec          (mtvec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [1:0] sel, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_sel   = sel;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ack"},   32'(trap_ack),       32'd0);
        check({tag, "_rv"},    32'(redirect_valid), 32'd0);
        check({tag, "_flush"}, 32'(flush),          32'd0);
        check({tag, "_busy"},  32'(busy),           32'd0);
        check({tag, "_rpc"},   redirect_pc,         32'h0);
        check({tag, "_priv"},  32'(cur_priv),       32'd3);
        check({tag, "_mie"},   32'(mie),            32'd0);
        check({tag, "_mpie"},  32'(mpie),           32'd0);
        check({tag, "_mpp"},   32'(mpp),            32'd3);
        check({tag, "_mepc"},  mepc,                32'h0);
        check({tag, "_mcause"}, mcause,             32'h0);
        check({tag, "_mtvec"}, mtvec,               32'h100);
    endtask

    initial begin
        rst_n          = 1'b1;
        trap_req       = 1'b0;
        trap_cause     = '0;
        trap_pc        = '0;
        mret_pulse     = 1'b0;
        csr_we         = 1'b0;
        csr_sel        = 2'b00;
        csr_wdata      = '0;
        redirect_ready = 1'b1;

        #2 rst_n = 1'b0;
        #2 check_reset("rst0");
        #8 rst_n = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // M-mode with mie=1, mpie=1, mpp=11
        csr_write(2'b00, 32'h0000_1888);
        check("ms_mie",  32'(mie),  32'd1);
        check("ms_mpie", 32'(mpie), 32'd1);
        check("ms_mpp",  32'(mpp),  32'd3);

        // Synchronous exception, direct mode
        trap_req   = 1'b1;
        trap_cause = 32'h0000_0002;
        trap_pc    = 32'h0000_1006;
        tick();
        check("t1_ack",  32'(trap_ack),       32'd1);
        check("t1_busy", 32'(busy),           32'd1);
        check("t1_rv0",  32'(redirect_valid), 32'd0);
        trap_req = 1'b0;
        tick();
        check("t1_ack_off", 32'(trap_ack),       32'd0);
        check("t1_rv",      32'(redirect_valid), 32'd1);
        check("t1_flush",   32'(flush),          32'd1);
        check("t1_rpc",     redirect_pc,         32'h100);
        check("t1_mepc",    mepc,                32'h1004);
        check("t1_mcause",  mcause,              32'h2);
        check("t1_mpie",    32'(mpie),           32'd1);
        check("t1_mie",     32'(mie),            32'd0);
        check("t1_mpp",     32'(mpp),            32'd3);
        check("t1_priv",    32'(cur_priv),       32'd3);
        tick();
        check("t1_done_rv",   32'(redirect_valid), 32'd0);
        check("t1_done_busy", 32'(busy),           32'd0);

        // MRET to U-mode
        csr_write(2'b00, 32'h0000_0080);
        csr_write(2'b01, 32'h0000_0403);
        check("mepc_align", mepc, 32'h400);
        mret_pulse = 1'b1;
        tick();
        mret_pulse = 1'b0;
        check("m_busy", 32'(busy),     32'd1);
        check("m_ack",  32'(trap_ack), 32'd0);
        tick();
        check("m_rv",   32'(redirect_valid), 32'd1);
        check("m_priv", 32'(cur_priv),       32'd0);
        check("m_mie",  32'(mie),            32'd1);
        check("m_mpie", 32'(mpie),           32'd1);
        check("m_mpp",  32'(mpp),            32'd0);
        check("m_rpc",  redirect_pc,         32'h400);
        tick();
        check("m_done_busy", 32'(busy), 32'd0);

        // MRET from U-mode is ignored
        mret_pulse = 1'b1;
        tick();
        mret_pulse = 1'b0;
        check("mret_u_busy", 32'(busy),     32'd0);
        check("mret_u_priv", 32'(cur_priv), 32'd0);

        // Vectored interrupt from U-mode, redirect held with ready low
        csr_write(2'b10, 32'h0000_0201);
        check("mtvec_vec", mtvec, 32'h201);
        trap_req       = 1'b1;
        trap_cause     = 32'h8000_0007;
        trap_pc        = 32'h0000_2000;
        redirect_ready = 1'b0;
        tick();
        check("t2_ack", 32'(trap_ack), 32'd1);
        trap_req = 1'b0;
        tick();
        check("t2_rpc",    redirect_pc,   32'h21C);
        check("t2_mpp",    32'(mpp),      32'd0);
        check("t2_priv",   32'(cur_priv), 32'd3);
        check("t2_mpie",   32'(mpie),     32'd1);
        check("t2_mie",    32'(mie),      32'd0);
        check("t2_mcause", mcause,        32'h8000_0007);
        check("t2_mepc",   mepc,          32'h2000);
        mret_pulse = 1'b1;
        csr_we     = 1'b1;
        csr_sel    = 2'b10;
        csr_wdata  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_rv", i),    32'(redirect_valid), 32'd1);
            check($sformatf("hold%0d_flush", i), 32'(flush),          32'd1);
            check($sformatf("hold%0d_rpc", i),   redirect_pc,         32'h21C);
        end
        check("hold_mtvec", mtvec,    32'h201);
        check("hold_priv",  32'(cur_priv), 32'd3);
        mret_pulse     = 1'b0;
        csr_we         = 1'b0;
        redirect_ready = 1'b1;
        tick();
        check("t2_done_busy", 32'(busy),           32'd0);
        check("t2_done_rv",   32'(redirect_valid), 32'd0);

        // Trap and MRET together: trap wins, CSR write dropped
        trap_req   = 1'b1;
        mret_pulse = 1'b1;
        trap_cause = 32'h0000_000B;
        trap_pc    = 32'h0000_3000;
        csr_we     = 1'b1;
        csr_sel    = 2'b10;
        csr_wdata  = 32'h0000_0400;
        tick();
        check("t3_ack",   32'(trap_ack), 32'd1);
        check("t3_mtvec", mtvec,         32'h201);
        trap_req   = 1'b0;
        mret_pulse = 1'b0;
        csr_we     = 1'b0;
        tick();
        check("t3_rpc",    redirect_pc, 32'h200);
        check("t3_mepc",   mepc,        32'h3000);
        check("t3_mcause", mcause,      32'hB);
        check("t3_mpp",    32'(mpp),    32'd3);
        tick();
        check("t3_done_busy", 32'(busy), 32'd0);

        // CSR legalisation
        csr_write(2'b00, 32'h0000_1000);
        check("legal_mpp",  32'(mpp),  32'd0);
        check("legal_mie",  32'(mie),  32'd0);
        check("legal_mpie", 32'(mpie), 32'd0);
        csr_write(2'b10, 32'h0000_0302);
        check("legal_mtvec", mtvec, 32'h300);
        csr_write(2'b11, 32'hFFFF_FFFF);
        check("rsvd_mtvec", mtvec, 32'h300);
        check("rsvd_mepc",  mepc,  32'h3000);

        // Async reset during REDIRECT
        trap_req       = 1'b1;
        trap_cause     = 32'h0000_0005;
        trap_pc        = 32'h0000_5000;
        redirect_ready = 1'b0;
        tick();
        trap_req = 1'b0;
        tick();
        check("t4_rv",  32'(redirect_valid), 32'd1);
        check("t4_rpc", redirect_pc,         32'h300);
        #2 rst_n = 1'b0;
        #1 check_reset("rst1");
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(busy),           32'd0);
        check("post_rst_rv",   32'(redirect_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
